// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, tables, GF(2^8) helpers and core types
package aes_pkg;
  localparam int NR = 10;
  typedef logic [127:0] block_t;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [0:10][7:0] RCON = 88'h00_01_02_04_08_10_20_40_80_1b_36;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] r);
    return r > 4'd10 ? 8'h00 : RCON[r];
  endfunction
endpackage

// File: rtl/aes128_iter_enc_if.sv
// aes128_iter_enc_if: plaintext/key input and ciphertext output handshakes
interface aes128_iter_enc_if import aes_pkg::*;;
  logic in_valid;
  logic in_ready;
  block_t in_data;
  block_t in_key;
  logic out_valid;
  logic out_ready;
  block_t out_data;
  logic busy;
  modport master (output in_valid, in_data, in_key, out_ready, input in_ready, out_valid, out_data, busy);
  modport slave (input in_valid, in_data, in_key, out_ready, output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/aes128_iter_enc_round.sv
// aes_round: one combinational AES round including its key-expansion step
module aes_round import aes_pkg::*; (
  input  block_t     block_in,
  input  block_t     rk_in,
  input  logic [3:0] round_idx,
  input  logic       is_final,
  output block_t     block_out,
  output block_t     rk_out
);
  word_t w [4];
  word_t t;
  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];
  // next round key: RotWord/SubWord/Rcon on the last word, then ripple xor
  always_comb begin
    t = {sbox(rk_in[23:16]), sbox(rk_in[15:8]), sbox(rk_in[7:0]), sbox(rk_in[31:24])} ^ {rcon(round_idx), 24'h0};
    w[0] = rk_in[127:96] ^ t;
    w[1] = rk_in[95:64] ^ w[0];
    w[2] = rk_in[63:32] ^ w[1];
    w[3] = rk_in[31:0] ^ w[2];
    rk_out = {w[0], w[1], w[2], w[3]};
  end
  // SubBytes, ShiftRows, MixColumns (skipped on the final round), AddRoundKey
  always_comb begin
    for (int i = 0; i < 16; i++) sb[i] = sbox(block_in[127-8*i -: 8]);
    for (int i = 0; i < 16; i++) sr[i] = sb[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) block_out[127-8*i -: 8] = (is_final ? sr[i] : mc[i]) ^ rk_out[127-8*i -: 8];
  end
endmodule

// File: rtl/aes128_iter_enc.sv
// aes128_iter_enc: iterative AES-128 encryptor with valid/ready handshakes
module aes128_iter_enc import aes_pkg::*; #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst_n,
  aes128_iter_enc_if.slave io
);
  localparam int STEPS = NR / ROUNDS_PER_CYCLE;
  localparam logic [3:0] LAST_RND = 4'(NR - ROUNDS_PER_CYCLE + 1);
  if ((ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 5) || STEPS * ROUNDS_PER_CYCLE != NR) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2 or 5");
  end
  state_e state, state_n;
  block_t blk, rk, out_data_r;
  logic [3:0] rnd;
  logic out_valid_r, in_rdy, accept, last;
  block_t cb [ROUNDS_PER_CYCLE+1];
  block_t ck [ROUNDS_PER_CYCLE+1];
  assign cb[0] = blk;
  assign ck[0] = rk;
  for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_rnd
    aes_round u_round (
      .block_in (cb[i]),
      .rk_in    (ck[i]),
      .round_idx(rnd + 4'(i)),
      .is_final (rnd + 4'(i) == 4'(NR)),
      .block_out(cb[i+1]),
      .rk_out   (ck[i+1])
    );
  end
  assign in_rdy = state == IDLE || (state == DONE && io.out_ready);
  assign accept = io.in_valid && in_rdy;
  assign last = state == RUN && rnd == LAST_RND;
  assign io.in_ready = in_rdy;
  assign io.out_valid = out_valid_r;
  assign io.out_data = out_data_r;
  assign io.busy = state == RUN;
  // next state: accepting from DONE goes straight back to RUN
  always_comb begin
    state_n = state;
    if (accept) state_n = RUN;
    else if (last) state_n = DONE;
    else if (state == DONE && io.out_ready) state_n = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // datapath: load round 0 on accept, advance the chain while running, latch result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk <= '0;
      rk <= '0;
      rnd <= '0;
      out_valid_r <= 1'b0;
      out_data_r <= '0;
    end else begin
      out_valid_r <= state_n == DONE;
      if (accept) begin
        blk <= io.in_data ^ io.in_key;
        rk <= io.in_key;
        rnd <= 4'd1;
      end else if (state == RUN) begin
        blk <= cb[ROUNDS_PER_CYCLE];
        rk <= ck[ROUNDS_PER_CYCLE];
        rnd <= rnd + 4'(ROUNDS_PER_CYCLE);
        if (last) out_data_r <= cb[ROUNDS_PER_CYCLE];
      end
    end
  end
endmodule
